// File: rtl/ysyx_25060170_mem_arb.sv
// IFU/LSU arbiter and AXI4-Lite-style bus sequencer: one outstanding transaction,
// alternating priority on ties, registered one-cycle response pulse to the owner.
module ysyx_25060170_mem_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_req_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wstrb,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_rdata,
  output logic        ls_rsp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [2:0]  dbg_state
);

  // Handshake rule: a transfer happens on a rising edge where valid && ready are both
  // high; a source holds valid and payload stable until that edge.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_D  = 3'd2,
    S_WR_AW = 3'd3,
    S_WR_B  = 3'd4,
    S_RSP   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 0 = IFU, 1 = LSU
  logic        owner_q, owner_d;            // 0 = IFU, 1 = LSU
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] if_rsp_data_q, if_rsp_data_d;
  logic        if_rsp_err_q, if_rsp_err_d;
  logic [31:0] ls_rsp_rdata_q, ls_rsp_rdata_d;
  logic        ls_rsp_err_q, ls_rsp_err_d;

  logic grant_ls, grant_if, accept, aw_fire, w_fire, both_done;

  // On a tie the requester that lost the previous grant wins.
  assign grant_ls  = ls_req_valid && (!if_req_valid || !last_grant_q);
  assign grant_if  = if_req_valid && !grant_ls;
  assign accept    = if_req_ready || ls_req_ready;
  assign aw_fire   = awvalid && awready;
  assign w_fire    = wvalid && wready;
  assign both_done = (aw_done_q || aw_fire) && (w_done_q || w_fire);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (grant_ls && ls_req_we) ? S_WR_AW : S_RD_A;
      S_RD_A:  if (arready) state_d = S_RD_D;
      S_RD_D:  if (rvalid) state_d = S_RSP;
      S_WR_AW: if (both_done) state_d = S_WR_B;
      S_WR_B:  if (bvalid) state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if_req_ready = (state_q == S_IDLE) && !rst && grant_if;
    ls_req_ready = (state_q == S_IDLE) && !rst && grant_ls;
    arvalid      = (state_q == S_RD_A);
    rready       = (state_q == S_RD_D);
    awvalid      = (state_q == S_WR_AW) && !aw_done_q;
    wvalid       = (state_q == S_WR_AW) && !w_done_q;
    bready       = (state_q == S_WR_B);
    if_rsp_valid = (state_q == S_RSP) && !owner_q;
    ls_rsp_valid = (state_q == S_RSP) && owner_q;
    araddr       = addr_q;
    awaddr       = addr_q;
    wdata        = wdata_q;
    wstrb        = wstrb_q;
    if_rsp_data  = if_rsp_data_q;
    if_rsp_err   = if_rsp_err_q;
    ls_rsp_rdata = ls_rsp_rdata_q;
    ls_rsp_err   = ls_rsp_err_q;
    dbg_state    = state_q;
  end

  always_comb begin
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    if_rsp_data_d  = if_rsp_data_q;
    if_rsp_err_d   = if_rsp_err_q;
    ls_rsp_rdata_d = ls_rsp_rdata_q;
    ls_rsp_err_d   = ls_rsp_err_q;
    case (state_q)
      S_IDLE: if (accept) begin
        last_grant_d = grant_ls;
        owner_d      = grant_ls;
        we_d         = grant_ls && ls_req_we;
        addr_d       = grant_ls ? ls_addr : if_addr;
        wdata_d      = grant_ls ? ls_wdata : 32'h0;
        wstrb_d      = grant_ls ? ls_wstrb : 4'h0;
        aw_done_d    = 1'b0;
        w_done_d     = 1'b0;
      end
      S_RD_D: if (rvalid) begin
        if (owner_q) begin
          ls_rsp_rdata_d = rdata;
          ls_rsp_err_d   = (rresp != 2'b00);
        end else begin
          if_rsp_data_d = rdata;
          if_rsp_err_d  = (rresp != 2'b00);
        end
      end
      S_WR_AW: begin
        // Flags are cleared once both sides complete so the next store starts clean.
        aw_done_d = both_done ? 1'b0 : (aw_done_q || aw_fire);
        w_done_d  = both_done ? 1'b0 : (w_done_q || w_fire);
      end
      S_WR_B: if (bvalid) begin
        ls_rsp_rdata_d = 32'h0;
        ls_rsp_err_d   = (bresp != 2'b00);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q   <= 1'b0;
      owner_q        <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 32'h0;
      wdata_q        <= 32'h0;
      wstrb_q        <= 4'h0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      if_rsp_data_q  <= 32'h0;
      if_rsp_err_q   <= 1'b0;
      ls_rsp_rdata_q <= 32'h0;
      ls_rsp_err_q   <= 1'b0;
    end else begin
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      if_rsp_data_q  <= if_rsp_data_d;
      if_rsp_err_q   <= if_rsp_err_d;
      ls_rsp_rdata_q <= ls_rsp_rdata_d;
      ls_rsp_err_q   <= ls_rsp_err_d;
    end
  end

endmodule
